bp_update_queue: RTL and testbench

In-order tracking queue for predicted branches, sitting between fetch/execute and the branch predictor's update port.
- Records each branch at prediction time and gives it an entry tag.
- Accepts out-of-order resolutions from execute by tag.
- Retires entries in program order, driving one registered predictor update per retirement.
- On a retired misprediction, raises a one-cycle flush/redirect and discards all younger entries.

---
 rtl/bp_update_queue_if.sv | 45 ++++
 rtl/bp_update_queue.sv | 145 ++++++++++++++
 tb/tb_bp_update_queue.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/bp_update_queue_if.sv
// Bundles fetch allocation, execute resolution and predictor update/redirect signals.
interface bp_update_queue_if #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAG_W = 3
);
  logic             alloc_valid;
  logic             alloc_ready;
  logic [31:0]      alloc_pc;
  logic             alloc_prediction;
  logic [31:0]      alloc_target;
  logic [TAG_W-1:0] alloc_tag;

  logic             resolve_valid;
  logic [TAG_W-1:0] resolve_tag;
  logic             resolve_taken;
  logic [31:0]      resolve_target;

  logic             update_valid;
  logic [31:0]      update_pc;
  logic             update_prediction;
  logic             update_actual;
  logic [31:0]      update_target;

  logic             flush_valid;
  logic [31:0]      redirect_pc;
  logic [TAG_W:0]   count;

  // Queue side
  modport slave (
    input  alloc_valid, alloc_pc, alloc_prediction, alloc_target,
    input  resolve_valid, resolve_tag, resolve_taken, resolve_target,
    output alloc_ready, alloc_tag,
    output update_valid, update_pc, update_prediction, update_actual, update_target,
    output flush_valid, redirect_pc, count
  );

  // Fetch/execute/predictor side
  modport master (
    output alloc_valid, alloc_pc, alloc_prediction, alloc_target,
    output resolve_valid, resolve_tag, resolve_taken, resolve_target,
    input  alloc_ready, alloc_tag,
    input  update_valid, update_pc, update_prediction, update_actual, update_target,
    input  flush_valid, redirect_pc, count
  );
endinterface

// File: rtl/bp_update_queue.sv
// In-order branch tracking queue: allocate at predict, resolve out of order by tag,
// retire in order with one registered predictor update, flush on retired mispredict.
module bp_update_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAG_W = 3
) (
  input logic                clk,
  input logic                rst,
  bp_update_queue_if.slave   bus
);

  localparam logic [TAG_W:0]   LP_FULL = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W-1:0] LP_ONE  = TAG_W'(1);

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_resolved;
  logic [31:0]      r_pc       [DEPTH];
  logic             r_pred     [DEPTH];
  logic [31:0]      r_pred_tgt [DEPTH];
  logic             r_act      [DEPTH];
  logic [31:0]      r_act_tgt  [DEPTH];

  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [TAG_W:0]   r_count;

  logic             r_upd_valid;
  logic [31:0]      r_upd_pc;
  logic             r_upd_pred;
  logic             r_upd_act;
  logic [31:0]      r_upd_tgt;
  logic             r_flush;
  logic [31:0]      r_redirect;

  logic             w_retire;
  logic             w_mispredict;
  logic             w_alloc_ready;
  logic             w_alloc_fire;
  logic             w_resolve_ok;
  logic [TAG_W:0]   w_count_d;

  // Retire/mispredict decode from the head entry, and allocation handshake.
  always_comb begin
    w_retire      = r_valid[r_head] && r_resolved[r_head];
    // A taken/taken pair still mispredicts if the target differs.
    w_mispredict  = w_retire &&
                    ((r_act[r_head] != r_pred[r_head]) ||
                     (r_act[r_head] && r_pred[r_head] &&
                      (r_act_tgt[r_head] != r_pred_tgt[r_head])));
    // No pop/push bypass: a full queue refuses even while retiring.
    w_alloc_ready = (r_count != LP_FULL) && !w_mispredict;
    w_alloc_fire  = bus.alloc_valid && w_alloc_ready;
    w_resolve_ok  = bus.resolve_valid && r_valid[bus.resolve_tag] &&
                    !r_resolved[bus.resolve_tag];
  end

  // Next occupancy.
  always_comb begin
    w_count_d = r_count;
    if (w_mispredict) begin
      w_count_d = '0;
    end else if (w_alloc_fire && !w_retire) begin
      w_count_d = r_count + 1'b1;
    end else if (!w_alloc_fire && w_retire) begin
      w_count_d = r_count - 1'b1;
    end
  end

  // Queue state, update and flush registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid     <= '0;
      r_resolved  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_pc[i]       <= '0;
        r_pred[i]     <= 1'b0;
        r_pred_tgt[i] <= '0;
        r_act[i]      <= 1'b0;
        r_act_tgt[i]  <= '0;
      end
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_upd_valid <= 1'b0;
      r_upd_pc    <= '0;
      r_upd_pred  <= 1'b0;
      r_upd_act   <= 1'b0;
      r_upd_tgt   <= '0;
      r_flush     <= 1'b0;
      r_redirect  <= '0;
    end else begin
      r_upd_valid <= 1'b0;
      r_flush     <= 1'b0;
      r_count     <= w_count_d;

      if (w_resolve_ok) begin
        r_resolved[bus.resolve_tag] <= 1'b1;
        r_act[bus.resolve_tag]      <= bus.resolve_taken;
        r_act_tgt[bus.resolve_tag]  <= bus.resolve_target;
      end

      if (w_alloc_fire) begin
        r_valid[r_tail]    <= 1'b1;
        r_resolved[r_tail] <= 1'b0;
        r_pc[r_tail]       <= bus.alloc_pc;
        r_pred[r_tail]     <= bus.alloc_prediction;
        r_pred_tgt[r_tail] <= bus.alloc_target;
        r_tail             <= r_tail + LP_ONE;
      end

      if (w_retire) begin
        r_upd_valid        <= 1'b1;
        r_upd_pc           <= r_pc[r_head];
        r_upd_pred         <= r_pred[r_head];
        r_upd_act          <= r_act[r_head];
        r_upd_tgt          <= r_act_tgt[r_head];
        r_valid[r_head]    <= 1'b0;
        r_resolved[r_head] <= 1'b0;
        r_head             <= r_head + LP_ONE;
      end

      // Flush overrides everything above, including a same-edge resolve of a younger entry.
      if (w_mispredict) begin
        r_flush    <= 1'b1;
        r_redirect <= r_act[r_head] ? r_act_tgt[r_head] : (r_pc[r_head] + 32'd4);
        r_valid    <= '0;
        r_resolved <= '0;
        r_head     <= '0;
        r_tail     <= '0;
      end
    end
  end

  assign bus.alloc_ready       = w_alloc_ready;
  assign bus.alloc_tag         = r_tail;
  assign bus.update_valid      = r_upd_valid;
  assign bus.update_pc         = r_upd_pc;
  assign bus.update_prediction = r_upd_pred;
  assign bus.update_actual     = r_upd_act;
  assign bus.update_target     = r_upd_tgt;
  assign bus.flush_valid       = r_flush;
  assign bus.redirect_pc       = r_redirect;
  assign bus.count             = r_count;

endmodule

// File: tb/tb_bp_update_queue.sv
// Directed bench for bp_update_queue; inputs change and outputs are checked on negedge.
module tb_bp_update_queue;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TAG_W = 3;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  bp_update_queue_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

  bp_update_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.alloc_valid      = 1'b0;
    bus.alloc_pc         = '0;
    bus.alloc_prediction = 1'b0;
    bus.alloc_target     = '0;
    bus.resolve_valid    = 1'b0;
    bus.resolve_tag      = '0;
    bus.resolve_taken    = 1'b0;
    bus.resolve_target   = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic alloc(input logic [31:0] pc, input logic pred, input logic [31:0] tgt);
    bus.alloc_valid      = 1'b1;
    bus.alloc_pc         = pc;
    bus.alloc_prediction = pred;
    bus.alloc_target     = tgt;
    tick();
    bus.alloc_valid      = 1'b0;
  endtask

  task automatic resolve(input logic [TAG_W-1:0] tag, input logic taken, input logic [31:0] tgt);
    bus.resolve_valid  = 1'b1;
    bus.resolve_tag    = tag;
    bus.resolve_taken  = taken;
    bus.resolve_target = tgt;
    tick();
    bus.resolve_valid  = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b0;
    idle_inputs();
    #12;
    // Asynchronous reset state while asserted
    check_eq("rst_upd_valid", 64'(bus.update_valid), 64'd0);
    check_eq("rst_flush", 64'(bus.flush_valid), 64'd0);
    check_eq("rst_redirect", 64'(bus.redirect_pc), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_count", 64'(bus.count), 64'd0);
    check_eq("rst_ready", 64'(bus.alloc_ready), 64'd1);

    // Single correctly predicted branch
    check_eq("t1_tag", 64'(bus.alloc_tag), 64'd0);
    alloc(32'h100, 1'b1, 32'h200);
    check_eq("t1_count1", 64'(bus.count), 64'd1);
    resolve(3'd0, 1'b1, 32'h200);
    check_eq("t1_no_early_upd", 64'(bus.update_valid), 64'd0);
    tick();
    check_eq("t1_upd_valid", 64'(bus.update_valid), 64'd1);
    check_eq("t1_upd_pc", 64'(bus.update_pc), 64'h100);
    check_eq("t1_upd_pred", 64'(bus.update_prediction), 64'd1);
    check_eq("t1_upd_act", 64'(bus.update_actual), 64'd1);
    check_eq("t1_upd_tgt", 64'(bus.update_target), 64'h200);
    check_eq("t1_flush", 64'(bus.flush_valid), 64'd0);
    check_eq("t1_count0", 64'(bus.count), 64'd0);
    tick();
    check_eq("t1_upd_pulse", 64'(bus.update_valid), 64'd0);

    // Out-of-order resolution, in-order retirement
    do_reset();
    alloc(32'h10, 1'b0, 32'h0);
    alloc(32'h20, 1'b0, 32'h0);
    alloc(32'h30, 1'b0, 32'h0);
    resolve(3'd2, 1'b0, 32'h0);
    check_eq("t2_hold_a", 64'(bus.update_valid), 64'd0);
    resolve(3'd1, 1'b0, 32'h0);
    check_eq("t2_hold_b", 64'(bus.update_valid), 64'd0);
    resolve(3'd0, 1'b0, 32'h0);
    check_eq("t2_hold_c", 64'(bus.update_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("t2_upd_valid%0d", i), 64'(bus.update_valid), 64'd1);
      check_eq($sformatf("t2_upd_pc%0d", i), 64'(bus.update_pc), 64'(32'h10 * (i + 1)));
    end
    tick();
    check_eq("t2_done_valid", 64'(bus.update_valid), 64'd0);
    check_eq("t2_done_count", 64'(bus.count), 64'd0);

    // Full queue, no bypass, tail wrap
    do_reset();
    for (int i = 0; i < 8; i++) alloc(32'h1000 + 32'(i * 4), 1'b0, 32'h0);
    check_eq("t3_full_count", 64'(bus.count), 64'd8);
    check_eq("t3_full_ready", 64'(bus.alloc_ready), 64'd0);
    alloc(32'h999, 1'b0, 32'h0);
    check_eq("t3_extra_ignored", 64'(bus.count), 64'd8);
    resolve(3'd0, 1'b0, 32'h0);
    check_eq("t3_no_bypass", 64'(bus.alloc_ready), 64'd0);
    bus.alloc_valid = 1'b1;
    bus.alloc_pc    = 32'h777;
    tick();
    bus.alloc_valid = 1'b0;
    check_eq("t3_retire_upd", 64'(bus.update_pc), 64'h1000);
    check_eq("t3_count7", 64'(bus.count), 64'd7);
    check_eq("t3_ready_again", 64'(bus.alloc_ready), 64'd1);
    check_eq("t3_wrap_tag", 64'(bus.alloc_tag), 64'd0);
    alloc(32'h2000, 1'b0, 32'h0);
    check_eq("t3_refill", 64'(bus.count), 64'd8);

    // Direction mispredict flushes younger entries
    do_reset();
    alloc(32'h40, 1'b0, 32'h0);
    alloc(32'h50, 1'b0, 32'h0);
    alloc(32'h60, 1'b0, 32'h0);
    resolve(3'd0, 1'b1, 32'h80);
    check_eq("t4_ready_blocked", 64'(bus.alloc_ready), 64'd0);
    tick();
    check_eq("t4_upd_valid", 64'(bus.update_valid), 64'd1);
    check_eq("t4_upd_act", 64'(bus.update_actual), 64'd1);
    check_eq("t4_upd_pred", 64'(bus.update_prediction), 64'd0);
    check_eq("t4_flush", 64'(bus.flush_valid), 64'd1);
    check_eq("t4_redirect", 64'(bus.redirect_pc), 64'h80);
    check_eq("t4_count", 64'(bus.count), 64'd0);
    resolve(3'd1, 1'b0, 32'h0);
    check_eq("t4_flush_pulse", 64'(bus.flush_valid), 64'd0);
    tick();
    check_eq("t4_stale_upd", 64'(bus.update_valid), 64'd0);
    check_eq("t4_stale_count", 64'(bus.count), 64'd0);

    // Target mispredict, then not-taken mispredict with PC wrap
    do_reset();
    alloc(32'h1000, 1'b1, 32'h300);
    resolve(3'd0, 1'b1, 32'h304);
    tick();
    check_eq("t5_tgt_flush", 64'(bus.flush_valid), 64'd1);
    check_eq("t5_tgt_redirect", 64'(bus.redirect_pc), 64'h304);
    alloc(32'hFFFF_FFFC, 1'b1, 32'h10);
    resolve(3'd0, 1'b0, 32'h0);
    tick();
    check_eq("t5_nt_flush", 64'(bus.flush_valid), 64'd1);
    check_eq("t5_nt_redirect", 64'(bus.redirect_pc), 64'h0);

    // Asynchronous reset mid-stream
    do_reset();
    for (int i = 0; i < 4; i++) alloc(32'h3000 + 32'(i * 4), 1'b0, 32'h0);
    resolve(3'd3, 1'b0, 32'h0);
    resolve(3'd2, 1'b0, 32'h0);
    resolve(3'd1, 1'b0, 32'h0);
    resolve(3'd0, 1'b0, 32'h0);
    tick();
    check_eq("t6_pre_upd", 64'(bus.update_valid), 64'd1);
    #1;
    rst = 1'b0;
    #1;
    check_eq("t6_async_upd", 64'(bus.update_valid), 64'd0);
    check_eq("t6_async_pc", 64'(bus.update_pc), 64'd0);
    check_eq("t6_async_count", 64'(bus.count), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check_eq("t6_post_upd_a", 64'(bus.update_valid), 64'd0);
    tick();
    check_eq("t6_post_upd_b", 64'(bus.update_valid), 64'd0);
    check_eq("t6_post_count", 64'(bus.count), 64'd0);

    // First resolution wins
    alloc(32'h500, 1'b1, 32'h600);
    alloc(32'h510, 1'b1, 32'h700);
    resolve(3'd1, 1'b1, 32'h700);
    resolve(3'd1, 1'b0, 32'h0);
    resolve(3'd0, 1'b1, 32'h600);
    tick();
    check_eq("t7_upd0_pc", 64'(bus.update_pc), 64'h500);
    tick();
    check_eq("t7_upd1_pc", 64'(bus.update_pc), 64'h510);
    check_eq("t7_upd1_act", 64'(bus.update_actual), 64'd1);
    check_eq("t7_upd1_tgt", 64'(bus.update_target), 64'h700);
    check_eq("t7_no_flush", 64'(bus.flush_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
